// File: rtl/mm_job_sequencer.sv
// Job sequencer for the matrix-multiply engine: buffers A then B, replays them framed, collects C.
// Optional COLLECT watchdog enabled by defining MM_SEQ_TIMEOUT_EN.
module mm_job_sequencer #(
    parameter int DW     = 8,
    parameter int RW     = 12,
    parameter int DEPTH  = 42,
    parameter int GAP    = 1,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    a_rows,
    input  logic [3:0]    a_cols,
    input  logic [3:0]    b_rows,
    input  logic [3:0]    b_cols,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic [DW-1:0] mm_in_data,
    output logic          mm_col_end,
    output logic          mm_row_end,
    input  logic          mm_valid,
    input  logic [RW-1:0] mm_out_data,
    output logic          res_valid,
    output logic [RW-1:0] res_data,
    output logic          res_last,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_FILL, S_SEND_A, S_GAP, S_SEND_B, S_COLLECT, S_DONE
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
`ifdef MM_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
    logic [15:0] wd;
`else
    // Watchdog compiled out: the timeout error bit can never be raised.
    localparam logic TO_NEVER = (TO_CYC < 0);
`endif

    state_t        state;
    logic [3:0]    ar, ac, br, bc;
    logic [5:0]    wr_ptr, rd_ptr;
    logic [3:0]    col;
    logic [7:0]    gap_cnt;
    logic [7:0]    res_cnt;
    logic          mm_valid_q;
    logic [DW-1:0] mem [DEPTH];

    // Sizes are computed at full width so oversize jobs cannot alias into legal ones.
    logic [7:0] na_full, nb_full, nres;
    logic [8:0] ntot_full;
    logic [5:0] na, ntot;
    logic       illegal;

    assign na_full   = {4'd0, ar} * {4'd0, ac};
    assign nb_full   = {4'd0, br} * {4'd0, bc};
    assign nres      = {4'd0, ar} * {4'd0, bc};
    assign ntot_full = {1'b0, na_full} + {1'b0, nb_full};
    assign na        = na_full[5:0];
    assign ntot      = ntot_full[5:0];
    assign illegal   = (ar == 4'd0) || (ac == 4'd0) || (br == 4'd0) || (bc == 4'd0) ||
                       (ac != br) || (ntot_full > 9'(DEPTH));

    always_ff @(posedge clk) begin
        if (state == S_FILL && src_valid && src_ready)
            mem[wr_ptr] <= src_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ar         <= '0;
            ac         <= '0;
            br         <= '0;
            bc         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            col        <= '0;
            gap_cnt    <= '0;
            res_cnt    <= '0;
            mm_valid_q <= 1'b0;
            src_ready  <= 1'b0;
            mm_in_data <= '0;
            mm_col_end <= 1'b0;
            mm_row_end <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= '0;
`ifdef MM_SEQ_TIMEOUT_EN
            wd         <= '0;
`endif
        end else begin
            mm_valid_q <= mm_valid;
            mm_in_data <= '0;
            mm_col_end <= 1'b0;
            mm_row_end <= 1'b0;
            res_valid  <= 1'b0;
            res_last   <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    ar    <= a_rows;
                    ac    <= a_cols;
                    br    <= b_rows;
                    bc    <= b_cols;
`ifdef MM_SEQ_TIMEOUT_EN
                    err   <= 2'b00;
`else
                    err   <= {TO_NEVER, 1'b0};
`endif
                    busy  <= 1'b1;
                    state <= S_CHECK;
                end
                S_CHECK: if (illegal) begin
                    err[0] <= 1'b1;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end else begin
                    src_ready <= 1'b1;
                    wr_ptr    <= '0;
                    state     <= S_FILL;
                end
                S_FILL: if (src_valid && src_ready) begin
                    wr_ptr <= wr_ptr + 6'd1;
                    if (wr_ptr == ntot - 6'd1) begin
                        src_ready <= 1'b0;
                        rd_ptr    <= '0;
                        col       <= '0;
                        state     <= S_SEND_A;
                    end
                end
                S_SEND_A: begin
                    mm_in_data <= mem[rd_ptr];
                    mm_col_end <= (col == ac - 4'd1);
                    mm_row_end <= (rd_ptr == na - 6'd1);
                    rd_ptr     <= rd_ptr + 6'd1;
                    col        <= (col == ac - 4'd1) ? 4'd0 : col + 4'd1;
                    if (rd_ptr == na - 6'd1) begin
                        col     <= '0;
                        gap_cnt <= '0;
                        state   <= (GAP == 0) ? S_SEND_B : S_GAP;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                    if (gap_cnt == GAP_LAST)
                        state <= S_SEND_B;
                end
                S_SEND_B: begin
                    mm_in_data <= mem[rd_ptr];
                    mm_col_end <= (col == bc - 4'd1);
                    mm_row_end <= (rd_ptr == ntot - 6'd1);
                    rd_ptr     <= rd_ptr + 6'd1;
                    col        <= (col == bc - 4'd1) ? 4'd0 : col + 4'd1;
                    if (rd_ptr == ntot - 6'd1) begin
                        res_cnt <= '0;
`ifdef MM_SEQ_TIMEOUT_EN
                        wd      <= '0;
`endif
                        state   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // MM may hold mm_valid for several cycles; only its rising edge is a result.
                    if (mm_valid && !mm_valid_q) begin
                        res_valid <= 1'b1;
                        res_data  <= mm_out_data;
                        res_cnt   <= res_cnt + 8'd1;
`ifdef MM_SEQ_TIMEOUT_EN
                        wd        <= '0;
`endif
                        if (res_cnt == nres - 8'd1) begin
                            res_last <= 1'b1;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
`ifdef MM_SEQ_TIMEOUT_EN
                    else if (wd == TO_LAST) begin
                        err[1] <= 1'b1;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        wd <= wd + 16'd1;
                    end
`endif
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Directed bench for mm_job_sequencer: table of jobs plus mid-job reset and recovery sequence.
module tb_mm_job_sequencer;
    localparam int DW  = 8;
    localparam int RW  = 12;
    localparam int GAP = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready;
    logic [DW-1:0] mm_in_data;
    logic          mm_col_end, mm_row_end;
    logic          mm_valid = 1'b0;
    logic [RW-1:0] mm_out_data = '0;
    logic          res_valid;
    logic [RW-1:0] res_data;
    logic          res_last, busy, done;
    logic [1:0]    err;

    always #5 clk = ~clk;

    mm_job_sequencer #(.DW(DW), .RW(RW), .DEPTH(42), .GAP(GAP), .TO_CYC(255)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .mm_in_data(mm_in_data), .mm_col_end(mm_col_end), .mm_row_end(mm_row_end),
        .mm_valid(mm_valid), .mm_out_data(mm_out_data),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int ar, ac, br, bc;
        bit tog;
        int pat;
        int exp_err;
    } vec_t;

    int errors = 0;
    int checks = 0;

    int src [64];
    int cmat [64];
    int na, nb, nres;
    int tr_d [700];
    bit tr_ce [700];
    bit tr_re [700];
    int res_d [$];
    bit res_l [$];
    int done_cyc, err_done, err_after, busy_after, acc_cnt, last_acc;
    int ready_seen, strobe_seen, ready_after_acc;
    bit aborted;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build(input vec_t v);
        na = v.ar * v.ac;
        nb = v.br * v.bc;
        for (int k = 0; k < na + nb; k++) begin
            case (v.pat)
                0: src[k] = (k < na) ? k + 1 : k - na + 1;
                1: src[k] = (k < na) ? (k % 3) + 1 : (k % 2) + 1;
                default: src[k] = (k < na) ? 3 : 4;
            endcase
        end
        nres = 0;
        if (v.exp_err == 0) begin
            nres = v.ar * v.bc;
            for (int i = 0; i < v.ar; i++)
                for (int j = 0; j < v.bc; j++) begin
                    cmat[i*v.bc+j] = 0;
                    for (int k = 0; k < v.ac; k++)
                        cmat[i*v.bc+j] += src[i*v.ac+k] * src[na+k*v.bc+j];
                end
        end
    endtask

    // Acts as source and as MM, one step per falling edge; records the DUT outputs.
    task automatic run_job(input vec_t v, input bit abort);
        int cyc = 0, sp = 0, s0 = -1, send_end = -1, emit = 0, mv_state = 0, hold = 0, post = 0;
        bit phase = 1'b1;
        bit fin = 1'b0;
        done_cyc = -1; err_done = -1; err_after = -1; busy_after = -1;
        acc_cnt = 0; last_acc = -1; ready_seen = 0; strobe_seen = 0; ready_after_acc = -1;
        aborted = 1'b0;
        res_d.delete();
        res_l.delete();
        for (int i = 0; i < 700; i++) begin
            tr_d[i] = 0; tr_ce[i] = 1'b0; tr_re[i] = 1'b0;
        end
        a_rows = 4'(v.ar); a_cols = 4'(v.ac); b_rows = 4'(v.br); b_cols = 4'(v.bc);
        start = 1'b1;
        while (cyc < 650 && !(fin && post >= 2)) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            tr_d[cyc]  = int'(mm_in_data);
            tr_ce[cyc] = mm_col_end;
            tr_re[cyc] = mm_row_end;
            if (src_ready) ready_seen++;
            if (mm_col_end || mm_row_end) strobe_seen++;
            if (res_valid) begin
                res_d.push_back(int'(res_data));
                res_l.push_back(res_last);
            end
            if (last_acc >= 0 && cyc == last_acc + 1) ready_after_acc = int'(src_ready);
            if (fin) begin
                post++;
                if (post == 2) begin
                    busy_after = int'(busy);
                    err_after  = int'(err);
                end
            end
            if (done && !fin) begin
                fin = 1'b1;
                done_cyc = cyc;
                err_done = int'(err);
            end
            if (abort && s0 >= 0 && cyc == s0 + na + GAP + 1) begin
                rst = 1'b0;
                src_valid = 1'b0;
                mm_valid = 1'b0;
                aborted = 1'b1;
                return;
            end
            if (v.exp_err == 0 && cyc == 5) begin
                start = 1'b1;
                a_rows = 4'd1; a_cols = 4'd1; b_rows = 4'd1; b_cols = 4'd1;
            end
            src_valid = 1'b0;
            if (sp < na + nb && (!v.tog || phase)) begin
                src_valid = 1'b1;
                src_data = DW'(src[sp]);
                if (src_ready) begin
                    sp++;
                    acc_cnt++;
                    if (sp == na + nb) begin
                        last_acc = cyc;
                        s0 = cyc + 2;
                        send_end = s0 + na + GAP + nb - 1;
                    end
                end
            end
            phase = ~phase;
            mm_valid = 1'b0;
            if (cyc == 3) begin
                mm_valid = 1'b1;
                mm_out_data = 12'hABC;
            end else if (send_end >= 0 && cyc >= send_end + 2 && emit < nres) begin
                if (mv_state == 0) begin
                    mm_valid = 1'b1;
                    mm_out_data = RW'(cmat[emit]);
                    hold = (emit % 2 == 0) ? 1 : 0;
                    mv_state = 1;
                end else if (hold > 0) begin
                    mm_valid = 1'b1;
                    hold--;
                end else begin
                    emit++;
                    mv_state = 0;
                end
            end
        end
        src_valid = 1'b0;
        mm_valid = 1'b0;
    endtask

    task automatic check_job(input vec_t v);
        int mism = 0;
        int s0, k, ed;
        bit ece, ere;
        check("done_seen", int'(done_cyc >= 0), 1);
        check("err_at_done", err_done, v.exp_err);
        check("err_held_after_done", err_after, v.exp_err);
        check("busy_after_done", busy_after, 0);
        if (v.exp_err != 0) begin
            check("illegal_done_latency", done_cyc, 2);
            check("illegal_src_ready_cycles", ready_seen, 0);
            check("illegal_mm_strobes", strobe_seen, 0);
        end else begin
            check("accept_count", acc_cnt, na + nb);
            check("src_ready_drop", ready_after_acc, 0);
            s0 = last_acc + 2;
            for (int i = 1; i <= done_cyc && i < 700; i++) begin
                ed = 0; ece = 1'b0; ere = 1'b0;
                if (last_acc >= 0 && i >= s0 && i < s0 + na) begin
                    k = i - s0;
                    ed = src[k];
                    ece = (k % v.ac) == v.ac - 1;
                    ere = (k == na - 1);
                end else if (last_acc >= 0 && i >= s0 + na + GAP && i < s0 + na + GAP + nb) begin
                    k = i - s0 - na - GAP;
                    ed = src[na+k];
                    ece = (k % v.bc) == v.bc - 1;
                    ere = (k == nb - 1);
                end
                if (tr_d[i] != ed || tr_ce[i] != ece || tr_re[i] != ere) mism++;
            end
            check("mm_stream_mismatch_cycles", mism, 0);
            check("result_count", res_d.size(), nres);
            for (int r = 0; r < res_d.size() && r < nres; r++) begin
                check($sformatf("result_%0d", r), res_d[r], cmat[r]);
                check($sformatf("res_last_%0d", r), int'(res_l[r]), int'(r == nres - 1));
            end
        end
    endtask

    vec_t tbl [6];
    int hand_c [4];

    initial begin
        logic [DW+RW+8:0] outs;
        vec_t v1;
        tbl[0] = '{2, 3, 3, 2, 1'b0, 0, 0};
        tbl[1] = '{2, 3, 3, 2, 1'b1, 0, 0};
        tbl[2] = '{2, 3, 2, 2, 1'b0, 0, 1};
        tbl[3] = '{5, 5, 5, 5, 1'b0, 1, 1};
        tbl[4] = '{5, 4, 4, 5, 1'b0, 1, 0};
        tbl[5] = '{0, 1, 1, 1, 1'b0, 0, 1};
        hand_c[0] = 22; hand_c[1] = 28; hand_c[2] = 49; hand_c[3] = 64;

        repeat (3) @(negedge clk);
        outs = {src_ready, mm_in_data, mm_col_end, mm_row_end, res_valid, res_data,
                res_last, busy, done, err};
        check("outputs_in_reset", int'(outs), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            build(tbl[t]);
            run_job(tbl[t], 1'b0);
            check_job(tbl[t]);
            if (tbl[t].pat == 0 && tbl[t].exp_err == 0)
                for (int r = 0; r < 4 && r < res_d.size(); r++)
                    check($sformatf("hand_result_job%0d_%0d", t, r), res_d[r], hand_c[r]);
            repeat (2) @(negedge clk);
        end

        build(tbl[0]);
        run_job(tbl[0], 1'b1);
        check("abort_reached_send_b", int'(aborted), 1);
        @(negedge clk);
        outs = {src_ready, mm_in_data, mm_col_end, mm_row_end, res_valid, res_data,
                res_last, busy, done, err};
        check("outputs_after_midjob_reset", int'(outs), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        v1 = '{1, 1, 1, 1, 1'b0, 2, 0};
        build(v1);
        run_job(v1, 1'b0);
        check_job(v1);
        if (res_d.size() > 0) check("one_by_one_result", res_d[0], 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
